// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: class codes, hold lengths,
// the class-to-length decode and the sequencer state encoding.
// Purely declarative; no logic, no latency, no flow control of its own.
package instr_sequencer_pkg;

  // Instruction class field values (instr[19:18])
  localparam logic [1:0] CLS_TERM  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  // Cycles the control unit spends on each class
  localparam logic [2:0] LEN_STD   = 3'd3;
  localparam logic [2:0] LEN_LOAD  = 3'd4;
  localparam logic [2:0] LEN_STORE = 3'd3;
  // The first instruction of a run also covers the control unit's reset exit
  localparam logic [2:0] LEN_FIRST_EXTRA = 3'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    LOAD0  = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

  // Hold length for a class; the terminator has no hold (returns 0).
  function automatic logic [2:0] cls_len(input logic [1:0] cls);
    logic [2:0] len;
    unique case (cls)
      CLS_STD:   len = LEN_STD;
      CLS_LOAD:  len = LEN_LOAD;
      CLS_STORE: len = LEN_STORE;
      default:   len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue scheduler in front of the control unit: each word is
// held on instr for its class's cycle count, next word prefetched so there is no bubble.
// Latency: start -> first instr 3 cycles (FETCH0, LOAD0); halt_req honoured at the next boundary.
// Ports: clk/rst (async, active-high); start, halt_req control; imem_rd_en/imem_addr/imem_data
// to a sync-read memory; instr/instr_valid/pc to the control unit; busy/done/wrap_err/retired status.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt_req,
  output logic                   imem_rd_en,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic                   wrap_err,
  output logic [CNT_WIDTH-1:0]   retired
);

  seq_state_t state, state_nxt;
  logic [2:0] hold_cnt;
  logic       halt_lat;

  logic [1:0] data_cls;
  logic       pc_last;
  logic       boundary;
  logic       halt_now;
  logic       end_run;

  assign data_cls = imem_data[INSTR_WIDTH-1 -: 2];
  assign pc_last  = (pc == {PC_BITS{1'b1}});
  assign boundary = (state == RUN) && (hold_cnt == 3'd1);
  // A request arriving on the boundary cycle itself still stops the run here
  assign halt_now = halt_lat | halt_req;
  // Priority: halt, then end of address space, then terminator (all go to HALTED)
  assign end_run  = halt_now | pc_last | (data_cls == CLS_TERM);

  assign busy = (state == FETCH0) || (state == LOAD0) || (state == RUN);
  assign done = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_rd_en = 1'b0;
    imem_addr  = '0;
    unique case (state)
      IDLE, HALTED: begin
        if (start) state_nxt = FETCH0;
      end
      FETCH0: begin
        imem_rd_en = 1'b1;
        imem_addr  = pc;
        state_nxt  = LOAD0;
      end
      LOAD0: begin
        state_nxt = (data_cls == CLS_TERM) ? HALTED : RUN;
      end
      RUN: begin
        // Prefetch one cycle ahead so the word is on imem_data at the boundary;
        // never wrap around to address 0.
        if ((hold_cnt == 3'd2) && !pc_last) begin
          imem_rd_en = 1'b1;
          imem_addr  = pc + 1'b1;
        end
        if (boundary && end_run) state_nxt = HALTED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      retired     <= '0;
      wrap_err    <= 1'b0;
      halt_lat    <= 1'b0;
      hold_cnt    <= 3'd0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc       <= '0;
            retired  <= '0;
            wrap_err <= 1'b0;
          end
        end
        LOAD0: begin
          if (data_cls != CLS_TERM) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            hold_cnt    <= cls_len(data_cls) + LEN_FIRST_EXTRA;
          end else begin
            instr       <= '0;
            instr_valid <= 1'b0;
          end
        end
        RUN: begin
          if (halt_req) halt_lat <= 1'b1;
          if (boundary) begin
            if (retired != {CNT_WIDTH{1'b1}}) retired <= retired + 1'b1;
            if (end_run) begin
              instr       <= '0;
              instr_valid <= 1'b0;
              halt_lat    <= 1'b0;
              hold_cnt    <= 3'd0;
              if (!halt_now && pc_last) wrap_err <= 1'b1;
            end else begin
              instr    <= imem_data;
              pc       <= pc + 1'b1;
              hold_cnt <= cls_len(data_cls);
            end
          end else begin
            hold_cnt <= hold_cnt - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        imem_rd_en;
  logic [4:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] instr;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic        wrap_err;
  logic [7:0]  retired;

  int checks;
  int failures;

  logic [19:0] mem [0:31];

  instr_sequencer #(.INSTR_WIDTH(20), .PC_BITS(5), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .done(done), .wrap_err(wrap_err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory that holds its last word between reads
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem[imem_addr];
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic        halt;
    logic [19:0] instr;
    logic        vld;
    logic        busy;
    logic        done;
    logic        rd;
    logic [4:0]  addr;
    logic [4:0]  pc;
    logic [7:0]  ret;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic h,
                              input logic [19:0] ins, input logic v, input logic b,
                              input logic d, input logic rd, input logic [4:0] a,
                              input logic [4:0] p, input logic [7:0] rt);
    vec_t x;
    x.rst = r; x.start = s; x.halt = h; x.instr = ins; x.vld = v; x.busy = b;
    x.done = d; x.rd = rd; x.addr = a; x.pc = p; x.ret = rt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog_mixed();
    for (int i = 0; i < 32; i++) mem[i] = 20'h0;
    mem[0] = 20'h56000;
    mem[1] = 20'h81010;
    mem[2] = 20'hC0020;
    mem[3] = 20'h00000;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done_reached"}, {31'd0, done}, 32'd1);
  endtask

  // Shared prefix of the mixed program: reset, start, FETCH0, LOAD0, 56000 x4, 81010 x2
  task automatic add_prefix(input logic halt_at_n8);
    tbl.push_back(mk(1, 1, 0, 20'h0,     0, 0, 0, 0, 5'd0, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h0,     0, 1, 0, 1, 5'd0, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h0,     0, 1, 0, 0, 5'd0, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h56000, 1, 1, 0, 0, 5'd0, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h56000, 1, 1, 0, 0, 5'd0, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h56000, 1, 1, 0, 1, 5'd1, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h56000, 1, 1, 0, 0, 5'd0, 5'd0, 8'd0));
    tbl.push_back(mk(0, 0, 0, 20'h81010, 1, 1, 0, 0, 5'd0, 5'd1, 8'd1));
    tbl.push_back(mk(0, 0, halt_at_n8, 20'h81010, 1, 1, 0, 0, 5'd0, 5'd1, 8'd1));
    tbl.push_back(mk(0, 0, 0, 20'h81010, 1, 1, 0, 1, 5'd2, 5'd1, 8'd1));
    tbl.push_back(mk(0, 0, 0, 20'h81010, 1, 1, 0, 0, 5'd0, 5'd1, 8'd1));
  endtask

  initial begin
    int seen_vld;
    int n, bad_reads, run_len, n_instr, bad_len;
    logic [4:0] prev_pc;

    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    checks = 0;
    failures = 0;
    load_prog_mixed();

    // Reset values visible before any clock edge
    #3;
    chk("reset instr", instr, 32'h0);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset pc", {27'd0, pc}, 32'd0);
    chk("reset retired", {24'd0, retired}, 32'd0);
    chk("reset busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset wrap_err", {31'd0, wrap_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mixed program, run to terminator
    add_prefix(1'b0);
    tbl.push_back(mk(0, 0, 0, 20'hC0020, 1, 1, 0, 0, 5'd0, 5'd2, 8'd2));
    tbl.push_back(mk(0, 0, 0, 20'hC0020, 1, 1, 0, 1, 5'd3, 5'd2, 8'd2));
    tbl.push_back(mk(0, 0, 0, 20'hC0020, 1, 1, 0, 0, 5'd0, 5'd2, 8'd2));
    tbl.push_back(mk(0, 0, 0, 20'h0,     0, 0, 1, 0, 5'd0, 5'd2, 8'd3));
    tbl.push_back(mk(0, 0, 0, 20'h0,     0, 0, 1, 0, 5'd0, 5'd2, 8'd3));
    // Same program, halt_req during the 2nd cycle of 81010
    add_prefix(1'b1);
    tbl.push_back(mk(0, 0, 0, 20'h0,     0, 0, 1, 0, 5'd0, 5'd1, 8'd2));
    tbl.push_back(mk(0, 0, 0, 20'h0,     0, 0, 1, 0, 5'd0, 5'd1, 8'd2));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) pulse_rst();
      chk($sformatf("row%0d instr", i), instr, {12'd0, tbl[i].instr});
      chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].vld});
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("row%0d imem_rd_en", i), {31'd0, imem_rd_en}, {31'd0, tbl[i].rd});
      chk($sformatf("row%0d imem_addr", i), {27'd0, imem_addr}, {27'd0, tbl[i].addr});
      chk($sformatf("row%0d pc", i), {27'd0, pc}, {27'd0, tbl[i].pc});
      chk($sformatf("row%0d retired", i), {24'd0, retired}, {24'd0, tbl[i].ret});
      chk($sformatf("row%0d wrap_err", i), {31'd0, wrap_err}, 32'd0);
      start = tbl[i].start;
      halt_req = tbl[i].halt;
      @(negedge clk);
    end
    start = 1'b0;
    halt_req = 1'b0;

    // Terminator at address 0
    for (int i = 0; i < 32; i++) mem[i] = 20'h0;
    pulse_rst();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_vld = 0;
    for (int k = 0; k < 5; k++) begin
      if (instr_valid) seen_vld = 1;
      @(negedge clk);
    end
    chk("term0 instr_valid_seen", seen_vld, 0);
    chk("term0 done", {31'd0, done}, 32'd1);
    chk("term0 retired", {24'd0, retired}, 32'd0);
    chk("term0 instr", instr, 32'h0);

    // Async reset mid-hold of the second instruction
    load_prog_mixed();
    pulse_rst();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst pre instr", instr, 32'h81010);
    chk("midrst pre retired", {24'd0, retired}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst instr", instr, 32'h0);
    chk("midrst instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst pc", {27'd0, pc}, 32'd0);
    chk("midrst retired", {24'd0, retired}, 32'd0);
    chk("midrst busy_done", {30'd0, busy, done}, 32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst idle_after", {30'd0, busy, done}, 32'd0);

    // start pulsed during RUN has no effect
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("runstart", 40);
    chk("runstart retired", {24'd0, retired}, 32'd3);
    chk("runstart pc", {27'd0, pc}, 32'd2);

    // All 32 words class 01: run off the end of the address space
    for (int i = 0; i < 32; i++) mem[i] = 20'h40000 | 20'(i);
    pulse_rst();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; bad_reads = 0; run_len = 0; n_instr = 0; bad_len = 0; prev_pc = 5'd0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (imem_rd_en && imem_addr == 5'd0) bad_reads++;
      if (instr_valid) begin
        if (run_len > 0 && pc == prev_pc) begin
          run_len++;
        end else begin
          if (run_len > 0) begin
            n_instr++;
            if (run_len != ((n_instr == 1) ? 4 : 3)) bad_len++;
          end
          prev_pc = pc;
          run_len = 1;
        end
      end
    end
    if (run_len > 0) begin
      n_instr++;
      if (run_len != ((n_instr == 1) ? 4 : 3)) bad_len++;
    end
    chk("wrap done", {31'd0, done}, 32'd1);
    chk("wrap instr_count", n_instr, 32);
    chk("wrap bad_hold_lengths", bad_len, 0);
    chk("wrap addr0_reads", bad_reads, 0);
    chk("wrap wrap_err", {31'd0, wrap_err}, 32'd1);
    chk("wrap retired", {24'd0, retired}, 32'd32);
    chk("wrap pc", {27'd0, pc}, 32'd31);

    // Restart from HALTED clears status and reruns from address 0
    load_prog_mixed();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun busy", {31'd0, busy}, 32'd1);
    chk("rerun wrap_err", {31'd0, wrap_err}, 32'd0);
    chk("rerun retired", {24'd0, retired}, 32'd0);
    chk("rerun fetch", {26'd0, imem_rd_en, imem_addr}, {26'd0, 1'b1, 5'd0});
    wait_done("rerun", 40);
    chk("rerun final retired", {24'd0, retired}, 32'd3);
    chk("rerun final pc", {27'd0, pc}, 32'd2);
    chk("rerun final wrap_err", {31'd0, wrap_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/issue scheduler placed in front of the control unit.
- Reads 20-bit instructions from a synchronous-read instruction memory and presents each one on instr.
- Holds each instruction stable for exactly the number of cycles the control unit's FSM spends on that instruction class, with no bubble between instructions.
- Stops on a class-00 terminator, on a host halt request, or at the end of the address space.

Parameters:
- INSTR_WIDTH, 20, instruction word width; class field is [19:18].
- PC_BITS, 5, instruction memory address width (32 words).
- CNT_WIDTH, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a program run from address 0; sampled only in IDLE/HALTED.
- halt_req  in  1  graceful stop request; sticky once seen in RUN.
- imem_rd_en  out  1  instruction memory read strobe (combinational from state).
- imem_addr  out  PC_BITS  read address (combinational); 0 when imem_rd_en=0.
- imem_data  in  INSTR_WIDTH  memory read data.
  - Valid the cycle after the read.
  - Memory holds the last read word until the next read.
- instr  out  INSTR_WIDTH  instruction to the control unit (registered).
- instr_valid  out  1  instr holds a real instruction.
- pc  out  PC_BITS  address of the instruction currently on instr.
- busy  out  1  state is FETCH0, LOAD0 or RUN.
- done  out  1  state is HALTED.
- wrap_err  out  1  run ended because the last address executed with no terminator.
- retired  out  CNT_WIDTH  instructions completed this run; saturates at all-ones.

Behaviour:
- Reset is asynchronous and active-high. On rst:
  - state=IDLE, instr=0, instr_valid=0, pc=0, retired=0, wrap_err=0, halt latch=0, hold_cnt=0.
  - Outputs take these values without waiting for a clock edge.
- Hold length L by class:
  - 01 (std) = 3, 10 (load) = 4, 11 (store) = 3.
  - The first instruction of a run gets L+1, covering the control unit's exit from its reset state.
  - Class 00 is the terminator.
- IDLE: on start=1 → FETCH0; pc<=0, retired<=0, wrap_err<=0.
- FETCH0: imem_rd_en=1, imem_addr=pc; → LOAD0.
- LOAD0: on the clock edge, decode imem_data[19:18].
  - 00 → HALTED; instr stays 0.
  - Otherwise: instr<=imem_data, instr_valid<=1, hold_cnt<=L+1; → RUN.
- RUN: hold_cnt decrements each cycle.
  - Prefetch: when hold_cnt==2 and pc != all-ones, imem_rd_en=1 and imem_addr=pc+1.
  - Boundary (hold_cnt==1), on the clock edge, in priority order:
    - retired increments (saturating).
    - If the halt latch is set → HALTED.
    - Else if pc == all-ones → HALTED with wrap_err<=1; no read of address 0 is ever issued.
    - Else if imem_data class == 00 → HALTED.
    - Else instr<=imem_data, pc<=pc+1, hold_cnt<=L(new); stay in RUN.
  - On every entry to HALTED: instr<=0, instr_valid<=0, halt latch cleared. pc keeps the last executed address.
- halt_req:
  - Latched on any RUN cycle, including the boundary cycle itself.
  - Never truncates the current instruction.
  - Ignored outside RUN.
- HALTED: done=1. On start=1 → FETCH0 with the same clears as IDLE.
- start is ignored while busy=1.
- Simultaneous events:
  - A prefetch that returns a terminator while halt is also latched: halt wins, with identical outcome.
  - rst asserted at any point (mid-hold, mid-fetch) aborts immediately with no partial retire.

Decomposition:
- Shared package holds:
  - Class constants CLS_TERM=2'b00, CLS_STD=2'b01, CLS_LOAD=2'b10, CLS_STORE=2'b11.
  - Hold lengths LEN_STD=3, LEN_LOAD=4, LEN_STORE=3, plus the first-instruction extra cycle.
  - A class-to-length function.
  - The sequencer state enum IDLE/FETCH0/LOAD0/RUN/HALTED.
- No sub-module: a single FSM plus hold counter; the length decode is the package function.

Test Plan:
- Mixed program: mem[0]=20'h56000, mem[1]=20'h81010, mem[2]=20'hC0020, mem[3]=0; pulse start.
  - Expect instr=56000 for 4 cycles, 81010 for 4, C0020 for 3, with no gap between them.
  - Then done=1, retired=3, instr=0, instr_valid=0, pc=2.
- mem[0]=0, start → HALTED after LOAD0; instr_valid never high, retired=0.
- Same program as the first scenario, halt_req pulsed during the 2nd cycle of 81010.
  - Expect 81010 held its full 4 cycles, then HALTED, retired=2, pc=1, C0020 never issued.
- All 32 words class 01, no terminator.
  - Expect 32 instructions (the first one 4 cycles, the rest 3), then wrap_err=1, done=1, retired=32.
  - imem_rd_en is never asserted with imem_addr=0 after the run starts.
- Assert rst asynchronously mid-hold of instruction 1 → instr=0, instr_valid=0, pc=0, retired=0 before the next clock edge; state IDLE.
- start pulsed during RUN → no effect. start in HALTED → rerun from address 0 with retired and wrap_err cleared.
